// File: rtl/fifo_stream_reader_pkg.sv
// Shared types for the FIFO stream reader: read-side FSM states, the
// output-buffer occupancy type and the read-issue admission check.
// No ports; imported by the interface users, the buffer and the top.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } rd_state_e;

  // Output buffer occupancy, 0..2.
  typedef logic [1:0] occ_t;

  localparam occ_t OCC_MAX = 2'd2;

  // A new read may be issued only if the word it returns next cycle is
  // guaranteed a buffer slot: words buffered plus the one already in
  // flight, minus the one leaving this cycle, must leave room.
  function automatic logic slot_free(occ_t occ, logic inflight, logic pop);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return committed < {1'b0, OCC_MAX};
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream leaving the FIFO stream reader.
// Signals: data_o (buffer head), valid_o, last_o (burst close) from the
// reader; ready_i from the consumer. master = reader, slave = consumer.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             last_o;
  logic             ready_i;

  modport master (
    output data_o,
    output valid_o,
    output last_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  valid_o,
    input  last_o,
    output ready_i
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry output buffer; push and pop may happen in the same cycle.
// Latency: a pushed word is visible at o_head_data the cycle after push.
// Backpressure: none inside; the caller never pushes into a full buffer.
// Ports: i_clk, i_rst_n (sync, active-low), i_push/i_push_data, i_pop,
//        o_head_data (oldest entry), o_occ (0..2).
module fifo_stream_reader_skid_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_data,
  output occ_t             o_occ
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  occ_t             r_occ;

  // Head/tail shift arrangement: the head is always the oldest word, so
  // the output needs no read-pointer mux.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_head <= i_push_data;
          end else begin
            r_tail <= i_push_data;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (r_occ == 2'd1) begin
            r_head <= i_push_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_push) begin
      assert (r_occ != OCC_MAX);
    end
  end

  assign o_head_data = r_head;
  assign o_occ       = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the fifo: issues reads, captures 1-cycle-latency data
// into a 2-entry buffer, and presents it as a valid/ready stream with burst
// marking and a running word count.
// Latency: FIFO non-empty (in RUN) to valid_o is 2 cycles; 1 word/cycle steady.
// Backpressure: reads stop once buffered + in-flight words would fill 2 slots;
// data_o is held while valid_o & !ready_i.
// Ports: clk_i, rst_n_i (sync, active-low), enable_i, fifo_empty_i,
//        fifo_rd_data_i, fifo_rd_req_o, strm (data_o/valid_o/last_o/ready_i),
//        word_cnt_o (accepted words, wrapping), busy_o (state != IDLE).
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 fifo_empty_i,
  input  logic [WIDTH-1:0]     fifo_rd_data_i,
  output logic                 fifo_rd_req_o,
  fifo_stream_reader_if.master strm,
  output logic [CNT_W-1:0]     word_cnt_o,
  output logic                 busy_o
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  rd_state_e r_state;
  rd_state_e w_state_nxt;

  logic              r_inflight;
  logic [BEAT_W-1:0] r_beat;
  logic [CNT_W-1:0]  r_word_cnt;

  logic              w_vld;
  logic              w_pop;
  logic              w_issue;
  logic              w_last;
  occ_t              w_occ;
  logic [WIDTH-1:0]  w_head;

  // A word read last cycle is pushed unconditionally; admission was
  // decided when the read was issued.
  fifo_stream_reader_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .i_clk       (clk_i),
    .i_rst_n     (rst_n_i),
    .i_push      (r_inflight),
    .i_push_data (fifo_rd_data_i),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_occ       (w_occ)
  );

  assign w_vld   = (w_occ != 2'd0);
  assign w_pop   = w_vld & strm.ready_i;
  assign w_last  = w_vld & (r_beat == BEAT_LAST);
  assign w_issue = (r_state == RUN) & enable_i & ~fifo_empty_i
                 & slot_free(w_occ, r_inflight, w_pop);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (enable_i) w_state_nxt = RUN;
      end
      RUN: begin
        if (!enable_i) w_state_nxt = STOP;
      end
      STOP: begin
        // Leave only once the last in-flight word has landed and drained.
        if (enable_i) begin
          w_state_nxt = RUN;
        end else if ((w_occ == 2'd0) && !r_inflight) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_inflight <= 1'b0;
      r_beat     <= '0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_pop) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
        // beat survives enable changes so a burst may span a stop/start.
        r_beat     <= w_last ? '0 : r_beat + BEAT_W'(1);
      end
    end
  end

  assign fifo_rd_req_o = w_issue;
  assign strm.data_o   = w_head;
  assign strm.valid_o  = w_vld;
  assign strm.last_o   = w_last;
  assign word_cnt_o    = r_word_cnt;
  assign busy_o        = (r_state != IDLE);

endmodule
